// File: rtl/processor_core.sv
// Two-cycle, non-pipelined 32-bit processor: FETCH latches the instruction, EXEC
// reads the register file, commits the result and drives the store/result port.
module processor_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    output logic [31:0] out,
    output logic [31:0] addr,
    output logic        rw,
    output logic        sys_dne
);

    localparam logic [0:0] FETCH = 1'b0;
    localparam logic [0:0] EXEC  = 1'b1;

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_XOR  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LI   = 6'h0A;
    localparam logic [5:0] OP_ST   = 6'h15;

    logic [0:0]  r_state;
    logic [31:0] r_ir;
    logic [31:0] r_regs [32];
    logic [31:0] r_out;
    logic [31:0] r_addr;
    logic        r_rw;
    logic        r_sysDne;

    logic [5:0]  w_opcode;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [15:0] w_imm16;
    logic [31:0] w_immSext;
    logic [31:0] w_immZext;
    logic [31:0] w_rsVal;
    logic [31:0] w_rtVal;
    logic        w_wrEn;
    logic [4:0]  w_wrIdx;
    logic [31:0] w_wrData;
    logic [31:0] w_nextOut;
    logic [31:0] w_nextAddr;
    logic        w_nextRw;

    assign w_opcode  = r_ir[31:26];
    assign w_rs      = r_ir[25:21];
    assign w_rt      = r_ir[20:16];
    assign w_rd      = r_ir[15:11];
    assign w_imm16   = r_ir[15:0];
    assign w_immSext = {{16{w_imm16[15]}}, w_imm16};
    assign w_immZext = {16'h0000, w_imm16};

    // R0 is hardwired to zero on the read side as well as discarded on write.
    assign w_rsVal = (w_rs == 5'd0) ? 32'h0 : r_regs[w_rs];
    assign w_rtVal = (w_rt == 5'd0) ? 32'h0 : r_regs[w_rt];

    always_comb begin
        w_wrEn     = 1'b0;
        w_wrIdx    = w_rd;
        w_wrData   = 32'h0;
        w_nextOut  = 32'h0;
        w_nextAddr = 32'h0;
        w_nextRw   = 1'b0;
        case (w_opcode)
            OP_ADD:  begin w_wrEn = 1'b1; w_wrData = w_rsVal + w_rtVal; end
            OP_SUB:  begin w_wrEn = 1'b1; w_wrData = w_rsVal - w_rtVal; end
            OP_AND:  begin w_wrEn = 1'b1; w_wrData = w_rsVal & w_rtVal; end
            OP_OR:   begin w_wrEn = 1'b1; w_wrData = w_rsVal | w_rtVal; end
            OP_XOR:  begin w_wrEn = 1'b1; w_wrData = w_rsVal ^ w_rtVal; end
            OP_ADDI: begin
                w_wrEn   = 1'b1;
                w_wrIdx  = w_rt;
                w_wrData = w_rsVal + w_immSext;
            end
            OP_LI: begin
                w_wrEn   = 1'b1;
                w_wrIdx  = w_rs;
                w_wrData = w_immZext;
            end
            OP_ST: begin
                w_nextAddr = w_rsVal + w_immSext;
                w_nextOut  = w_rtVal;
                w_nextRw   = 1'b1;
            end
            default: ;
        endcase
        // Writes to R0 are dropped, so the visible result must be zero too.
        if (w_wrEn) begin
            w_nextOut = (w_wrIdx == 5'd0) ? 32'h0 : w_wrData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= FETCH;
            r_ir     <= 32'h0;
            r_out    <= 32'h0;
            r_addr   <= 32'h0;
            r_rw     <= 1'b0;
            r_sysDne <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            case (r_state)
                FETCH: begin
                    r_ir     <= instruction;
                    r_rw     <= 1'b0;
                    r_sysDne <= 1'b0;
                    r_state  <= EXEC;
                end
                default: begin
                    if (w_wrEn && (w_wrIdx != 5'd0)) begin
                        r_regs[w_wrIdx] <= w_wrData;
                    end
                    r_out    <= w_nextOut;
                    r_addr   <= w_nextAddr;
                    r_rw     <= w_nextRw;
                    r_sysDne <= 1'b1;
                    r_state  <= FETCH;
                end
            endcase
        end
    end

    assign out     = r_out;
    assign addr    = r_addr;
    assign rw      = r_rw;
    assign sys_dne = r_sysDne;

endmodule

// File: tb/tb_processor_core.sv
// Self-checking bench for processor_core: directed vector table, reset corner
// cases, then random instructions compared against an instruction-level model.
module tb_processor_core;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] out;
    logic [31:0] addr;
    logic        rw;
    logic        sys_dne;

    int checkCount;
    int failCount;

    logic [31:0] modelRegs [32];
    logic [31:0] prevOut;
    logic [31:0] prevAddr;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] expOut;
        logic [31:0] expAddr;
        logic        expRw;
    } vec_t;

    vec_t vecs [16];

    processor_core dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .out         (out),
        .addr        (addr),
        .rw          (rw),
        .sys_dne     (sys_dne)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) modelRegs[i] = 32'h0;
        prevOut  = 32'h0;
        prevAddr = 32'h0;
    endtask

    // Architectural effect of one instruction, straight from the ISA rules.
    task automatic modelStep(input logic [31:0] instr, output logic [31:0] eo,
                             output logic [31:0] ea, output logic er);
        logic [5:0]  op;
        logic [31:0] a, b, sx, res;
        int          dst;
        bit          wr;
        op  = instr[31:26];
        a   = modelRegs[instr[25:21]];
        b   = modelRegs[instr[20:16]];
        sx  = {{16{instr[15]}}, instr[15:0]};
        eo  = 0; ea = 0; er = 0; wr = 0; dst = 0; res = 0;
        case (op)
            6'h01: begin wr = 1; dst = instr[15:11]; res = a + b; end
            6'h02: begin wr = 1; dst = instr[15:11]; res = a - b; end
            6'h03: begin wr = 1; dst = instr[15:11]; res = a & b; end
            6'h04: begin wr = 1; dst = instr[15:11]; res = a | b; end
            6'h05: begin wr = 1; dst = instr[15:11]; res = a ^ b; end
            6'h08: begin wr = 1; dst = instr[20:16]; res = a + sx; end
            6'h0A: begin wr = 1; dst = instr[25:21]; res = {16'h0, instr[15:0]}; end
            6'h15: begin ea = a + sx; eo = b; er = 1; end
            default: ;
        endcase
        if (wr && dst != 0) begin
            modelRegs[dst] = res;
            eo = res;
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        instruction = $urandom;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
    endtask

    // One full instruction: FETCH edge then EXEC edge, checking both phases.
    task automatic applyStimulus(input string name, input logic [31:0] instr,
                                 input logic [31:0] eo, input logic [31:0] ea, input logic er);
        instruction = instr;
        @(posedge clk);
        #1;
        checkOutput({name, " fetch rw"}, {31'h0, rw}, 32'h0);
        checkOutput({name, " fetch sys_dne"}, {31'h0, sys_dne}, 32'h0);
        checkOutput({name, " fetch out hold"}, out, prevOut);
        checkOutput({name, " fetch addr hold"}, addr, prevAddr);
        instruction = $urandom;
        @(posedge clk);
        #1;
        checkOutput({name, " out"}, out, eo);
        checkOutput({name, " addr"}, addr, ea);
        checkOutput({name, " rw"}, {31'h0, rw}, {31'h0, er});
        checkOutput({name, " sys_dne"}, {31'h0, sys_dne}, 32'h1);
        prevOut  = eo;
        prevAddr = ea;
    endtask

    initial begin
        logic [31:0] eo, ea, ri;
        logic        er;
        logic [5:0]  ops [9];

        checkCount = 0;
        failCount  = 0;

        vecs[0]  = '{32'h28200008, 32'h00000008, 32'h0, 1'b0};
        vecs[1]  = '{32'h2840000B, 32'h0000000B, 32'h0, 1'b0};
        vecs[2]  = '{32'h54220000, 32'h0000000B, 32'h8, 1'b1};
        vecs[3]  = '{32'h04221800, 32'h00000013, 32'h0, 1'b0};
        vecs[4]  = '{32'h54030004, 32'h00000013, 32'h4, 1'b1};
        vecs[5]  = '{32'h28200001, 32'h00000001, 32'h0, 1'b0};
        vecs[6]  = '{32'h08012800, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[7]  = '{32'h2004FFFF, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[8]  = '{32'h28001234, 32'h00000000, 32'h0, 1'b0};
        vecs[9]  = '{32'h54000000, 32'h00000000, 32'h0, 1'b1};
        vecs[10] = '{32'hFFFFFFFF, 32'h00000000, 32'h0, 1'b0};
        vecs[11] = '{32'h0C433000, 32'h00000003, 32'h0, 1'b0};
        vecs[12] = '{32'h10433800, 32'h0000001B, 32'h0, 1'b0};
        vecs[13] = '{32'h14434000, 32'h00000018, 32'h0, 1'b0};
        vecs[14] = '{32'h2029FFFE, 32'hFFFFFFFF, 32'h0, 1'b0};
        vecs[15] = '{32'h29408000, 32'h00008000, 32'h0, 1'b0};

        doReset();
        checkOutput("reset out", out, 32'h0);
        checkOutput("reset addr", addr, 32'h0);
        checkOutput("reset rw", {31'h0, rw}, 32'h0);
        checkOutput("reset sys_dne", {31'h0, sys_dne}, 32'h0);

        for (int i = 0; i < 16; i++) begin
            modelStep(vecs[i].instr, eo, ea, er);
            applyStimulus($sformatf("vec%0d", i), vecs[i].instr, vecs[i].expOut, vecs[i].expAddr, vecs[i].expRw);
        end

        // Pulse must drop after one cycle once instructions stop completing.
        instruction = 32'hFC000000;
        @(posedge clk);
        #1;
        checkOutput("dne drop", {31'h0, sys_dne}, 32'h0);
        checkOutput("rw drop", {31'h0, rw}, 32'h0);
        @(posedge clk);
        #1;
        prevOut  = 32'h0;
        prevAddr = 32'h0;

        // Reset landing on the EXEC edge of LI R1,5 aborts it.
        instruction = 32'h28200005;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        modelReset();
        checkOutput("abort sys_dne", {31'h0, sys_dne}, 32'h0);
        checkOutput("abort out", out, 32'h0);
        checkOutput("abort rw", {31'h0, rw}, 32'h0);
        modelStep(32'h54010000, eo, ea, er);
        applyStimulus("abort R1 read", 32'h54010000, 32'h0, 32'h0, 1'b1);

        ops = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h15, 6'h00};
        for (int n = 0; n < 300; n++) begin
            ri = $urandom;
            ri[31:26] = ops[$urandom_range(0, 8)];
            if (ri[31:26] == 6'h00) ri[31:26] = 6'($urandom_range(16, 63));
            if (ri[31:26] == 6'h15 || ri[31:26] == 6'h0A || ri[31:26] == 6'h08) ri[31:26] = ri[31:26];
            modelStep(ri, eo, ea, er);
            applyStimulus($sformatf("rnd%0d 0x%08h", n, ri), ri, eo, ea, er);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/processor_core.md
# processor_core

Two-cycle, non-pipelined 32-bit processor with a 32-entry register file and a store-only external memory port. Each instruction arrives on an external `instruction` bus, is latched in a FETCH cycle and committed in an EXECUTE cycle. Register results are exposed on `out`; stores drive `addr`/`out` with `rw` asserted. `sys_dne` pulses once per completed instruction. This is the top-level CPU block; instruction supply and memory are external.

## Interface
- No parameters.
- `clk` — input, 1 bit — single clock; all state updates on the rising edge.
- `reset` — input, 1 bit — synchronous, active-high.
- `instruction` — input, 32 bits — current instruction. It must be held stable across the FETCH edge.
- `out` — output, 32 bits — registered. Carries the store data or the write-back result.
- `addr` — output, 32 bits — registered. Carries the store address; 0 for non-store instructions.
- `rw` — output, 1 bit — registered. 1 means a memory write is presented this cycle.
- `sys_dne` — output, 1 bit — registered. One-cycle pulse when an instruction completes.

## Operation
- Fields:
  - opcode = [31:26]
  - rs = [25:21]
  - rt = [20:16]
  - rd = [15:11]
  - imm16 = [15:0]
- Register file: R0–R31, 32 bits each. R0 reads as 0 and writes to it are discarded.
- Opcodes:
  - 0x01 ADD: R[rd] = R[rs] + R[rt]
  - 0x02 SUB: R[rd] = R[rs] − R[rt]
  - 0x03 AND: R[rd] = R[rs] & R[rt]
  - 0x04 OR: R[rd] = R[rs] | R[rt]
  - 0x05 XOR: R[rd] = R[rs] ^ R[rt]
  - 0x08 ADDI: R[rt] = R[rs] + signext(imm16)
  - 0x0A LI: R[rs] = zeroext(imm16). The destination is field [25:21].
  - 0x15 ST: addr = R[rs] + signext(imm16); out = R[rt]; rw = 1. No register write.
  - All other opcodes are NOPs: no register write; out = 0, addr = 0, rw = 0; `sys_dne` still pulses.
- Arithmetic is 32-bit modulo 2^32. No flags, no exceptions.
- Register-writing instructions: out = the value written (0 if the destination is R0); addr = 0; rw = 0.
- FSM has 2 states:
  - FETCH: IR ← instruction; go to EXEC.
  - EXEC: decode IR; perform the register write; register out/addr/rw; sys_dne ← 1; go to FETCH.
- Operands are read in EXEC from the register file. A result written in one instruction is visible to the next instruction.

## Timing
- Reset (edge with reset=1):
  - state = FETCH
  - IR = 0, all registers = 0
  - out = 0, addr = 0, rw = 0, sys_dne = 0
- Reset has priority over any state. Reset mid-instruction (in EXEC) aborts the instruction: no register write, no pulse.
- Instruction latency: 2 clocks. The FETCH edge samples `instruction`; the EXEC edge commits.
- After the FETCH edge: rw = 0 and sys_dne = 0. `out` and `addr` hold their previous values.
- After the EXEC edge: out/addr/rw are valid and sys_dne = 1, for exactly one cycle (until the next FETCH edge).
- Throughput: one instruction per 2 cycles. The supplier changes `instruction` after a FETCH-phase edge; the first FETCH follows reset deassertion.
- `instruction` is ignored on EXEC edges.

## Test plan
- Reset, then three instructions:
  - 0x28200008 (LI R1,8)
  - 0x2840000B (LI R2,0xB)
  - 0x54220000 (ST)
  - Required response:
    - After each LI EXEC edge: out = 8, then out = 0xB; rw = 0; sys_dne = 1 for one cycle.
    - After the ST EXEC edge: addr = 0x8, out = 0xB, rw = 1, sys_dne = 1. All drop to rw = 0 and sys_dne = 0 after the next edge.
- With R1 = 8 and R2 = 0xB, ADD R3,R1,R2 (0x04221800) → out = 0x13. A subsequent ST R3 with offset 4 (0x54030004 for rs = R0) → addr = 4, out = 0x13.
- SUB wrap-around:
  - R0 − R1 with R1 = 1 → out = 0xFFFFFFFF.
  - ADDI R4,R0,0xFFFF → out = 0xFFFFFFFF (sign-extended).
- R0 write: LI R0,0x1234 (0x28001234) → out = 0. A following ST with rs = R0, rt = R0 → addr = 0, out = 0.
- Reset mid-operation: assert reset on the EXEC edge of LI R1,5 → R1 remains 0, sys_dne stays 0. The next instruction after deassertion is fetched normally.
- Undefined opcode 0x3F → no state change, out = addr = rw = 0, sys_dne pulses once.
